// File: rtl/wb_commit_stage_pkg.sv
// Shared definitions for the multi-lane writeback/commit stage: lane bus
// layout, field offsets, exception codes and a lane unpack helper.
package wb_commit_stage_pkg;

    localparam int WS_LANE_WD   = 113;

    localparam int PC_LSB       = 0;
    localparam int DEST_LSB     = 32;
    localparam int GR_WE_LSB    = 37;
    localparam int RESULT_LSB   = 41;
    localparam int EXC_BIT      = 73;
    localparam int EXCCODE_LSB  = 74;
    localparam int BD_BIT       = 79;
    localparam int BADVADDR_LSB = 80;
    localparam int ERET_BIT     = 112;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    typedef struct packed {
        logic        eret;
        logic [31:0] badvaddr;
        logic        bd;
        logic [4:0]  exccode;
        logic        exc;
        logic [31:0] result;
        logic [3:0]  gr_we;
        logic [4:0]  dest;
        logic [31:0] pc;
    } ws_lane_t;

    function automatic ws_lane_t unpack_lane(input logic [WS_LANE_WD-1:0] raw);
        ws_lane_t l;
        l.pc       = raw[PC_LSB +: 32];
        l.dest     = raw[DEST_LSB +: 5];
        l.gr_we    = raw[GR_WE_LSB +: 4];
        l.result   = raw[RESULT_LSB +: 32];
        l.exc      = raw[EXC_BIT];
        l.exccode  = raw[EXCCODE_LSB +: 5];
        l.bd       = raw[BD_BIT];
        l.badvaddr = raw[BADVADDR_LSB +: 32];
        l.eret     = raw[ERET_BIT];
        return l;
    endfunction

endpackage

// File: rtl/wb_commit_stage_lane_picker.sv
// In-order lane selection for the head bundle: hands out up to RF_PORTS
// valid lanes from index h, stops at the first exception/ERET lane, and
// reports where the next cycle resumes or whether the bundle is done.
module wb_lane_picker
    import wb_commit_stage_pkg::*;
#(
    parameter int LANES    = 2,
    parameter int RF_PORTS = 1,
    parameter int LIDX_W   = 1
) (
    input  logic                       head_valid,
    input  logic [LANES-1:0]           lane_valid,
    input  logic [LANES-1:0]           lane_event,
    input  logic [LIDX_W-1:0]          h,
    output logic [RF_PORTS-1:0]        port_valid,
    output logic [RF_PORTS*LIDX_W-1:0] port_lane,
    output logic                       event_valid,
    output logic [LIDX_W-1:0]          event_lane,
    output logic [LIDX_W-1:0]          next_h,
    output logic                       pop
);

    int   slots;
    logic stop;

    // Walk lanes oldest-first; a valid lane that finds no free port becomes the resume point.
    always_comb begin
        port_valid  = '0;
        port_lane   = '0;
        event_valid = 1'b0;
        event_lane  = '0;
        next_h      = '0;
        pop         = 1'b0;
        slots       = 0;
        stop        = 1'b0;
        if (head_valid) begin
            for (int i = 0; i < LANES; i++) begin
                if (!stop && (i >= int'(h)) && lane_valid[i]) begin
                    if (slots == RF_PORTS) begin
                        stop   = 1'b1;
                        next_h = LIDX_W'(i);
                    end else if (lane_event[i]) begin
                        stop        = 1'b1;
                        event_valid = 1'b1;
                        event_lane  = LIDX_W'(i);
                    end else begin
                        for (int p = 0; p < RF_PORTS; p++) begin
                            if (p == slots) begin
                                port_valid[p]                 = 1'b1;
                                port_lane[p*LIDX_W +: LIDX_W] = LIDX_W'(i);
                            end else begin
                                port_valid[p] = port_valid[p];
                            end
                        end
                        slots = slots + 1;
                    end
                end else begin
                    stop = stop;
                end
            end
            pop = !stop;
        end else begin
            pop = 1'b0;
        end
    end

endmodule

// File: rtl/wb_commit_stage.sv
// Multi-lane commit stage: buffers memory-stage bundles, retires lanes in
// program order through RF_PORTS register-file ports and raises precise
// exception/ERET requests toward CP0.
module wb_commit_stage
    import wb_commit_stage_pkg::*;
#(
    parameter int LANES    = 2,
    parameter int RF_PORTS = 1,
    parameter int DEPTH    = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        ms_to_ws_valid,
    input  logic [LANES-1:0]            ms_lane_valid,
    input  logic [LANES*WS_LANE_WD-1:0] ms_to_ws_bus,
    output logic                        ws_allowin,
    output logic [RF_PORTS*4-1:0]       rf_we,
    output logic [RF_PORTS*5-1:0]       rf_waddr,
    output logic [RF_PORTS*32-1:0]      rf_wdata,
    output logic [31:0]                 ws_pending_mask,
    output logic                        exc_req,
    output logic [31:0]                 exc_pc,
    output logic [31:0]                 exc_badvaddr,
    output logic                        exc_bd,
    output logic [4:0]                  exc_code,
    output logic                        eret_req,
    output logic                        send_flush,
    output logic [RF_PORTS*32-1:0]      debug_wb_pc,
    output logic [RF_PORTS*4-1:0]       debug_wb_rf_wen,
    output logic [RF_PORTS*5-1:0]       debug_wb_rf_wnum,
    output logic [RF_PORTS*32-1:0]      debug_wb_rf_wdata
);

    localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    logic [LANES*WS_LANE_WD-1:0] buf_data   [DEPTH];
    logic [LANES-1:0]            buf_lvalid [DEPTH];
    logic [PTR_W-1:0]            head_ptr;
    logic [PTR_W-1:0]            tail_ptr;
    logic [CNT_W-1:0]            count;
    logic [LIDX_W-1:0]           h;

    ws_lane_t                    head_lane [LANES];
    logic [LANES-1:0]            head_event;
    logic                        non_empty;
    logic                        push;
    logic                        pop_now;
    logic                        fire;
    logic [PTR_W-1:0]            scan_idx;

    logic [RF_PORTS-1:0]         port_valid;
    logic [RF_PORTS*LIDX_W-1:0]  port_lane;
    logic                        event_valid;
    logic [LIDX_W-1:0]           event_lane;
    logic [LIDX_W-1:0]           next_h;
    logic                        pick_pop;

    assign non_empty  = (count != '0);
    assign ws_allowin = (count < CNT_W'(DEPTH));
    assign push       = ms_to_ws_valid & ws_allowin;
    assign pop_now    = non_empty & pick_pop;
    assign fire       = event_valid & ~flush;
    assign send_flush = exc_req | eret_req;

    assign debug_wb_rf_wen   = rf_we;
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

    // Decode the lanes of the oldest buffered bundle.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            head_lane[l]  = unpack_lane(buf_data[head_ptr][l*WS_LANE_WD +: WS_LANE_WD]);
            head_event[l] = head_lane[l].exc | head_lane[l].eret;
        end
    end

    wb_lane_picker #(
        .LANES    (LANES),
        .RF_PORTS (RF_PORTS),
        .LIDX_W   (LIDX_W)
    ) u_picker (
        .head_valid  (non_empty),
        .lane_valid  (buf_lvalid[head_ptr]),
        .lane_event  (head_event),
        .h           (h),
        .port_valid  (port_valid),
        .port_lane   (port_lane),
        .event_valid (event_valid),
        .event_lane  (event_lane),
        .next_h      (next_h),
        .pop         (pick_pop)
    );

    // Route picked lanes onto write ports and the exception lane onto the CP0 request; flush silences both.
    always_comb begin
        rf_we        = '0;
        rf_waddr     = '0;
        rf_wdata     = '0;
        debug_wb_pc  = '0;
        exc_req      = 1'b0;
        eret_req     = 1'b0;
        exc_pc       = 32'h0;
        exc_badvaddr = 32'h0;
        exc_bd       = 1'b0;
        exc_code     = 5'h0;
        for (int p = 0; p < RF_PORTS; p++) begin
            for (int l = 0; l < LANES; l++) begin
                if (port_valid[p] && !flush && (port_lane[p*LIDX_W +: LIDX_W] == LIDX_W'(l))) begin
                    rf_we[p*4 +: 4]        = head_lane[l].gr_we;
                    rf_waddr[p*5 +: 5]     = head_lane[l].dest;
                    rf_wdata[p*32 +: 32]   = head_lane[l].result;
                    debug_wb_pc[p*32 +: 32] = head_lane[l].pc;
                end else begin
                    rf_we = rf_we;
                end
            end
        end
        for (int l = 0; l < LANES; l++) begin
            if (fire && (event_lane == LIDX_W'(l))) begin
                exc_req      = head_lane[l].exc;
                eret_req     = ~head_lane[l].exc;
                exc_pc       = head_lane[l].pc;
                exc_badvaddr = head_lane[l].badvaddr;
                exc_bd       = head_lane[l].bd;
                exc_code     = head_lane[l].exccode;
            end else begin
                exc_req = exc_req;
            end
        end
    end

    // Scoreboard of destinations still owed by unretired lanes (head from h, plus all younger bundles).
    always_comb begin
        ws_pending_mask = 32'h0;
        scan_idx        = head_ptr;
        for (int j = 0; j < DEPTH; j++) begin
            scan_idx = head_ptr + PTR_W'(j);
            if (CNT_W'(j) < count) begin
                for (int l = 0; l < LANES; l++) begin
                    if (buf_lvalid[scan_idx][l] && ((j > 0) || (LIDX_W'(l) >= h)) &&
                        (buf_data[scan_idx][l*WS_LANE_WD + GR_WE_LSB +: 4] != 4'h0)) begin
                        ws_pending_mask[buf_data[scan_idx][l*WS_LANE_WD + DEST_LSB +: 5]] = 1'b1;
                    end else begin
                        ws_pending_mask = ws_pending_mask;
                    end
                end
            end else begin
                ws_pending_mask = ws_pending_mask;
            end
        end
        ws_pending_mask[0] = 1'b0;
    end

    // Buffer pointers, occupancy and head lane index; reset, flush and a committed exception empty the buffer.
    always_ff @(posedge clk) begin
        if (reset || flush || fire) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            h        <= '0;
        end else begin
            if (push) begin
                buf_data[tail_ptr]   <= ms_to_ws_bus;
                buf_lvalid[tail_ptr] <= ms_lane_valid;
                tail_ptr             <= tail_ptr + PTR_W'(1);
            end else begin
                tail_ptr <= tail_ptr;
            end
            if (pop_now) begin
                head_ptr <= head_ptr + PTR_W'(1);
                h        <= '0;
            end else if (non_empty) begin
                h <= next_h;
            end else begin
                h <= h;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop_now);
        end
    end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Randomised bench for wb_commit_stage: a 2-port and a 1-port instance share
// stimulus and are each compared every cycle against a queue-based model of
// in-order lane retirement.
module tb_wb_commit_stage;
    import wb_commit_stage_pkg::*;

    typedef struct packed {
        int          bid;
        bit          empty;
        bit          exc;
        bit          eret;
        bit          bd;
        logic [4:0]  dest;
        logic [4:0]  code;
        logic [3:0]  we;
        logic [31:0] pc;
        logic [31:0] res;
        logic [31:0] bv;
    } mrec_t;

    logic clk = 1'b0;
    logic reset, flush, ms_valid;
    logic [1:0] lane_valid;
    logic [2*WS_LANE_WD-1:0] bus;

    logic a_allowin, a_exc, a_eret, a_sf, a_bd;
    logic [7:0]  a_we, a_dwen;
    logic [9:0]  a_waddr, a_dwnum;
    logic [63:0] a_wdata, a_dpc, a_dwdata;
    logic [31:0] a_mask, a_epc, a_ebv;
    logic [4:0]  a_ecode;

    logic b_allowin, b_exc, b_eret, b_sf, b_bd;
    logic [3:0]  b_we, b_dwen;
    logic [4:0]  b_waddr, b_dwnum;
    logic [31:0] b_wdata, b_dpc, b_dwdata;
    logic [31:0] b_mask, b_epc, b_ebv;
    logic [4:0]  b_ecode;

    int checks = 0;
    int errors = 0;
    int next_bid = 0;
    mrec_t mq0[$];
    mrec_t mq1[$];
    int cnt0 = 0;
    int cnt1 = 0;
    mrec_t in_lane [2];
    logic [4:0] codes [7];

    always #5 clk = ~clk;

    wb_commit_stage #(.LANES(2), .RF_PORTS(2), .DEPTH(2)) dut_p2 (
        .clk(clk), .reset(reset), .flush(flush), .ms_to_ws_valid(ms_valid),
        .ms_lane_valid(lane_valid), .ms_to_ws_bus(bus), .ws_allowin(a_allowin),
        .rf_we(a_we), .rf_waddr(a_waddr), .rf_wdata(a_wdata), .ws_pending_mask(a_mask),
        .exc_req(a_exc), .exc_pc(a_epc), .exc_badvaddr(a_ebv), .exc_bd(a_bd),
        .exc_code(a_ecode), .eret_req(a_eret), .send_flush(a_sf), .debug_wb_pc(a_dpc),
        .debug_wb_rf_wen(a_dwen), .debug_wb_rf_wnum(a_dwnum), .debug_wb_rf_wdata(a_dwdata)
    );

    wb_commit_stage #(.LANES(2), .RF_PORTS(1), .DEPTH(2)) dut_p1 (
        .clk(clk), .reset(reset), .flush(flush), .ms_to_ws_valid(ms_valid),
        .ms_lane_valid(lane_valid), .ms_to_ws_bus(bus), .ws_allowin(b_allowin),
        .rf_we(b_we), .rf_waddr(b_waddr), .rf_wdata(b_wdata), .ws_pending_mask(b_mask),
        .exc_req(b_exc), .exc_pc(b_epc), .exc_badvaddr(b_ebv), .exc_bd(b_bd),
        .exc_code(b_ecode), .eret_req(b_eret), .send_flush(b_sf), .debug_wb_pc(b_dpc),
        .debug_wb_rf_wen(b_dwen), .debug_wb_rf_wnum(b_dwnum), .debug_wb_rf_wdata(b_dwdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WS_LANE_WD-1:0] mk_lane(input mrec_t r);
        return {r.eret, r.bv, r.bd, r.code, r.exc, r.res, r.we, r.dest, r.pc};
    endfunction

    function automatic mrec_t ln(input logic [31:0] pc, input logic [4:0] dest, input logic [31:0] data);
        mrec_t r = '0;
        r.pc = pc; r.dest = dest; r.res = data; r.we = 4'hf;
        return r;
    endfunction

    // Expected outputs of instance k from the model, compare, then advance the model across the edge.
    task automatic model_step(input int k);
        mrec_t q[$];
        mrec_t evl;
        int cnt, np, nret, hb;
        bit ev, popb, push;
        logic [3:0] ewe [2];
        logic [4:0] ead [2];
        logic [31:0] edat [2], epc [2];
        logic [31:0] emask;
        logic [7:0] o_we, o_dwen;
        logic [9:0] o_ad, o_dwnum;
        logic [63:0] o_dat, o_pc, o_dwdata;
        string pf;
        if (k == 0) begin
            q = mq0; cnt = cnt0; np = 2; pf = "p2";
            o_we = a_we; o_ad = a_waddr; o_dat = a_wdata; o_pc = a_dpc;
            o_dwen = a_dwen; o_dwnum = a_dwnum; o_dwdata = a_dwdata;
        end else begin
            q = mq1; cnt = cnt1; np = 1; pf = "p1";
            o_we = {4'h0, b_we}; o_ad = {5'h0, b_waddr}; o_dat = {32'h0, b_wdata}; o_pc = {32'h0, b_dpc};
            o_dwen = {4'h0, b_dwen}; o_dwnum = {5'h0, b_dwnum}; o_dwdata = {32'h0, b_dwdata};
        end
        for (int s = 0; s < 2; s++) begin
            ewe[s] = 4'h0; ead[s] = 5'h0; edat[s] = 32'h0; epc[s] = 32'h0;
        end
        ev = 1'b0; evl = '0; nret = 0; popb = 1'b0; emask = 32'h0;
        foreach (q[i]) begin
            if (!q[i].empty && q[i].we != 4'h0 && q[i].dest != 5'd0) emask[q[i].dest] = 1'b1;
        end
        if (!flush && q.size() > 0) begin
            hb = q[0].bid;
            if (q[0].empty) begin
                nret = 1;
            end else begin
                for (int s = 0; s < np; s++) begin
                    if (s >= q.size()) break;
                    if (q[s].bid != hb) break;
                    if (q[s].exc || q[s].eret) begin
                        ev = 1'b1; evl = q[s];
                        break;
                    end
                    ewe[s] = q[s].we; ead[s] = q[s].dest; edat[s] = q[s].res; epc[s] = q[s].pc;
                    nret++;
                end
            end
            popb = (nret > 0) && ((nret >= q.size()) || (q[nret].bid != hb));
        end
        if (!reset) begin
            for (int s = 0; s < np; s++) begin
                check_eq($sformatf("%s.rf_we%0d", pf, s), 32'(o_we[s*4 +: 4]), 32'(ewe[s]));
                check_eq($sformatf("%s.rf_waddr%0d", pf, s), 32'(o_ad[s*5 +: 5]), 32'(ead[s]));
                check_eq($sformatf("%s.rf_wdata%0d", pf, s), o_dat[s*32 +: 32], edat[s]);
                check_eq($sformatf("%s.dbg_pc%0d", pf, s), o_pc[s*32 +: 32], epc[s]);
                check_eq($sformatf("%s.dbg_wen%0d", pf, s), 32'(o_dwen[s*4 +: 4]), 32'(ewe[s]));
                check_eq($sformatf("%s.dbg_wnum%0d", pf, s), 32'(o_dwnum[s*5 +: 5]), 32'(ead[s]));
                check_eq($sformatf("%s.dbg_wdata%0d", pf, s), o_dwdata[s*32 +: 32], edat[s]);
            end
            check_eq({pf, ".exc_req"}, 32'(k == 0 ? a_exc : b_exc), 32'(ev && evl.exc));
            check_eq({pf, ".eret_req"}, 32'(k == 0 ? a_eret : b_eret), 32'(ev && !evl.exc));
            check_eq({pf, ".send_flush"}, 32'(k == 0 ? a_sf : b_sf), 32'(ev));
            check_eq({pf, ".exc_pc"}, k == 0 ? a_epc : b_epc, ev ? evl.pc : 32'h0);
            check_eq({pf, ".exc_badvaddr"}, k == 0 ? a_ebv : b_ebv, ev ? evl.bv : 32'h0);
            check_eq({pf, ".exc_bd"}, 32'(k == 0 ? a_bd : b_bd), 32'(ev && evl.bd));
            check_eq({pf, ".exc_code"}, 32'(k == 0 ? a_ecode : b_ecode), ev ? 32'(evl.code) : 32'h0);
            check_eq({pf, ".allowin"}, 32'(k == 0 ? a_allowin : b_allowin), 32'(cnt < 2));
            check_eq({pf, ".pending"}, k == 0 ? a_mask : b_mask, emask);
        end
        if (reset || flush || ev) begin
            q.delete();
            cnt = 0;
        end else begin
            push = ms_valid && (cnt < 2);
            repeat (nret) void'(q.pop_front());
            if (popb) cnt--;
            if (push) begin
                if (lane_valid == 2'b00) begin
                    mrec_t e = '0;
                    e.empty = 1'b1; e.bid = next_bid;
                    q.push_back(e);
                end else begin
                    for (int l = 0; l < 2; l++) begin
                        if (lane_valid[l]) begin
                            mrec_t r = in_lane[l];
                            r.bid = next_bid; r.empty = 1'b0;
                            q.push_back(r);
                        end
                    end
                end
                cnt++;
            end
        end
        if (k == 0) begin mq0 = q; cnt0 = cnt; end
        else begin mq1 = q; cnt1 = cnt; end
    endtask

    task automatic step();
        @(negedge clk);
        model_step(0);
        model_step(1);
        next_bid++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [1:0] lv, input mrec_t l0, input mrec_t l1,
                         input bit fl, input bit rs);
        ms_valid = v; lane_valid = lv; flush = fl; reset = rs;
        in_lane[0] = l0; in_lane[1] = l1;
        bus = {mk_lane(l1), mk_lane(l0)};
        step();
    endtask

    function automatic mrec_t rnd_lane();
        mrec_t r = '0;
        int sel;
        r.pc   = $urandom;
        r.dest = 5'($urandom_range(0, 7));
        r.res  = $urandom;
        sel    = $urandom_range(0, 3);
        r.we   = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hf : 4'($urandom);
        r.exc  = ($urandom_range(0, 15) == 0);
        r.eret = ($urandom_range(0, 15) == 0);
        r.bd   = 1'($urandom);
        r.code = codes[$urandom_range(0, 6)];
        r.bv   = $urandom;
        return r;
    endfunction

    initial begin
        mrec_t z, x0, x1;
        int r;
        logic [1:0] lv;
        codes[0] = EXC_INT; codes[1] = EXC_ADEL; codes[2] = EXC_ADES; codes[3] = EXC_SYS;
        codes[4] = EXC_BP;  codes[5] = EXC_RI;   codes[6] = EXC_OV;
        z = '0;
        ms_valid = 1'b0; lane_valid = 2'b00; bus = '0; flush = 1'b0; reset = 1'b1;
        in_lane[0] = z; in_lane[1] = z;
        drive(1'b0, 2'b00, z, z, 1'b0, 1'b1);
        drive(1'b0, 2'b00, z, z, 1'b0, 1'b1);

        // back-to-back bundles, then drain
        repeat (4) drive(1'b1, 2'b11, ln(32'h100, 5'd3, 32'hA), ln(32'h104, 5'd4, 32'hB), 1'b0, 1'b0);
        repeat (4) drive(1'b0, 2'b00, z, z, 1'b0, 1'b0);

        // lane 1 exception followed by a younger bundle
        x1 = ln(32'h204, 5'd6, 32'h66);
        x1.exc = 1'b1; x1.code = EXC_ADEL; x1.bv = 32'hDEAD0001;
        drive(1'b1, 2'b11, ln(32'h200, 5'd5, 32'h55), x1, 1'b0, 1'b0);
        drive(1'b1, 2'b11, ln(32'h208, 5'd7, 32'h77), ln(32'h20c, 5'd8, 32'h88), 1'b0, 1'b0);
        repeat (3) drive(1'b0, 2'b00, z, z, 1'b0, 1'b0);

        // lane 0 eret with a younger writing lane
        x0 = ln(32'h300, 5'd0, 32'h0);
        x0.we = 4'h0; x0.eret = 1'b1;
        drive(1'b1, 2'b11, x0, ln(32'h304, 5'd9, 32'h99), 1'b0, 1'b0);
        repeat (2) drive(1'b0, 2'b00, z, z, 1'b0, 1'b0);

        // flush with buffered bundles and a simultaneous enqueue
        drive(1'b1, 2'b11, ln(32'h400, 5'd10, 32'h1), ln(32'h404, 5'd11, 32'h2), 1'b0, 1'b0);
        drive(1'b1, 2'b11, ln(32'h408, 5'd12, 32'h3), ln(32'h40c, 5'd13, 32'h4), 1'b0, 1'b0);
        drive(1'b1, 2'b11, ln(32'h410, 5'd14, 32'h5), ln(32'h414, 5'd15, 32'h6), 1'b1, 1'b0);
        repeat (2) drive(1'b0, 2'b00, z, z, 1'b0, 1'b0);

        // empty bundle, single-lane bundles
        drive(1'b1, 2'b00, z, z, 1'b0, 1'b0);
        drive(1'b1, 2'b10, z, ln(32'h504, 5'd17, 32'h17), 1'b0, 1'b0);
        drive(1'b1, 2'b01, ln(32'h508, 5'd18, 32'h18), z, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 2'b00, z, z, 1'b0, 1'b0);

        // reset while the 1-port instance has a partially retired head
        drive(1'b1, 2'b11, ln(32'h600, 5'd19, 32'h19), ln(32'h604, 5'd20, 32'h20), 1'b0, 1'b0);
        drive(1'b0, 2'b00, z, z, 1'b0, 1'b0);
        drive(1'b0, 2'b00, z, z, 1'b0, 1'b1);
        drive(1'b1, 2'b11, ln(32'h700, 5'd21, 32'h21), ln(32'h704, 5'd22, 32'h22), 1'b0, 1'b0);
        repeat (3) drive(1'b0, 2'b00, z, z, 1'b0, 1'b0);

        // randomised traffic
        for (int c = 0; c < 3000; c++) begin
            r  = $urandom_range(0, 7);
            lv = (r == 0) ? 2'b00 : (r < 3) ? 2'b01 : (r < 4) ? 2'b10 : 2'b11;
            drive($urandom_range(0, 9) < 7, lv, rnd_lane(), rnd_lane(),
                  $urandom_range(0, 24) == 0, $urandom_range(0, 149) == 0);
        end
        repeat (4) drive(1'b0, 2'b00, z, z, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_commit_stage.md
Name: wb_commit_stage

Overview:
- Parametrised successor of the single-lane writeback stage. Accepts LANES-wide bundles from the memory stage into a DEPTH-entry commit buffer.
- Retires lanes strictly in program order, at up to RF_PORTS register-file writes per cycle.
- Resolves exceptions and ERET precisely: older lanes commit, the faulting lane and younger lanes are squashed.
- Sits between ms and the register file / CP0. CP0 stays a separate block driven by this stage's request outputs.

Parameters:
- LANES, 2, instructions per bundle (1..4)
- RF_PORTS, 1, register-file write ports (1..LANES)
- DEPTH, 2, commit-buffer bundle entries (power of 2, >=2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  external pipeline flush
- ms_to_ws_valid  in  1  bundle valid
- ms_lane_valid  in  LANES  per-lane valid within bundle
- ms_to_ws_bus  in  LANES*`WS_LANE_WD  per-lane {eret, badvaddr[31:0], bd, exccode[4:0], exc, result[31:0], gr_we[3:0], dest[4:0], pc[31:0]}, lane 0 = oldest
- ws_allowin  out  1  buffer can accept a bundle
- rf_we  out  RF_PORTS*4  byte write enables
- rf_waddr  out  RF_PORTS*5  write addresses
- rf_wdata  out  RF_PORTS*32  write data
- ws_pending_mask  out  32  bit r set if any unretired buffered lane has dest==r and gr_we!=0 (r0 is always 0)
- exc_req  out  1  exception commit pulse to CP0
- exc_pc / exc_badvaddr  out  32/32  faulting lane pc / badvaddr
- exc_bd  out  1  delay-slot flag
- exc_code  out  5  exception code
- eret_req  out  1  ERET commit pulse
- send_flush  out  1  exc_req | eret_req
- debug_wb_pc  out  RF_PORTS*32  per-port pc
- debug_wb_rf_wen  out  RF_PORTS*4  equals rf_we
- debug_wb_rf_wnum  out  RF_PORTS*5  equals rf_waddr
- debug_wb_rf_wdata  out  RF_PORTS*32  equals rf_wdata

Behaviour:
- Reset (sync, active-high): buffer empty, head lane index 0, all outputs 0, ws_allowin=1.
- Enqueue: when ms_to_ws_valid && ws_allowin, store the bundle at the tail on the clock edge. ws_allowin = (count<DEPTH). It is registered-count based, with no combinational path from retire.
- A bundle with all ms_lane_valid=0 is accepted, then dropped at the head in one cycle with no writes.
- Latency: a bundle accepted at edge t is eligible to retire in cycle t+1. With LANES<=RF_PORTS, full throughput is 1 bundle per cycle.
- Retire, each cycle with a non-empty buffer:
  - Scan the head bundle from lane index h (skipping invalid lanes).
  - Retire up to RF_PORTS valid lanes in order.
  - Map retired lanes to ports 0..k-1 in age order. Unused ports output we=0.
  - A lane with gr_we=0 consumes a port slot but writes nothing.
- State per head: IDLE (empty), PARTIAL (h>0). When the last valid lane retires: pop the head, h<=0.
- Exception or ERET at the first lane L with (exc|eret) in the head:
  - Lanes older than L retire first, possibly in earlier cycles.
  - In the cycle L would retire: L's rf_we=0; assert exc_req or eret_req for exactly 1 cycle with L's fields.
  - Lanes retiring in the same cycle that are older than L still write.
  - At the edge: buffer cleared, h<=0. Lanes younger than L and all younger bundles are discarded.
  - exc has priority over eret in the same lane.
- flush input high:
  - All rf_we, exc_req and eret_req are forced 0 in that cycle.
  - Buffer is cleared at the edge.
  - A simultaneous enqueue is discarded.
- Simultaneous enqueue and pop: count unchanged. Pointers wrap mod DEPTH.
- ws_pending_mask is combinational from buffer contents (head lanes >= h plus all younger entries). Cleared with the buffer.

Decomposition:
- Shared header mycpu.h gets:
  - `WS_LANE_WD (113)
  - lane field offset macros
  - exccode constants
- One sub-module, wb_lane_picker: combinational in-order selection of up to RF_PORTS lanes from the head bundle starting at h. Outputs:
  - per-port lane index and valid
  - first-exception lane
  - next h and pop flag

Test Plan:
- LANES=2, RF_PORTS=2: bundles {pc 0x100 dest 3 data 0xA, pc 0x104 dest 4 data 0xB} back-to-back -> both ports write the same cycle, one cycle after accept; 1 bundle/cycle sustained.
- RF_PORTS=1, same bundle -> port 0 writes r3=0xA, then next cycle r4=0xB; ws_allowin drops when count reaches DEPTH=2; no bundle lost.
- Lane 1 exc (code 0x04, badvaddr 0xDEAD0001, pc 0x204) -> lane 0 writes; exc_req pulses one cycle with pc 0x204; r of lane 1 not written; following queued bundle never writes; buffer empty next cycle.
- Lane 0 eret with lane 1 valid write -> eret_req=1, no rf writes that cycle, send_flush=1.
- flush asserted while 2 bundles buffered and ms_to_ws_valid=1 -> no writes, ws_pending_mask=0 and ws_allowin=1 next cycle.
- Reset asserted mid-PARTIAL (after lane 0 retired) -> next cycle all outputs 0, pending mask 0, subsequent bundle retires from lane 0.
